// File: rtl/expr_seq_pkg.sv
// Shared types and constants for the expression-vector sequencer: FSM states,
// LFSR taps, MISR polynomial and default widths.
package expr_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_VEC_W = 60;
  localparam int DEF_RES_W = 90;
  localparam int DEF_CNT_W = 16;

  // x^64+x^63+x^61+x^60+1 -> taps on bits 63,62,60,59
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit multiple-input signature register: CRC-32 style shift with the
// folded result XORed in on every enabled cycle.
module misr32
  import expr_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [31:0] i_fold,
  output logic [31:0] o_sig
);

  logic [31:0] r_sig;
  logic [31:0] w_shift;

  assign w_shift = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sig <= '0;
    end else if (i_init) begin
      r_sig <= 32'hFFFF_FFFF;
    end else if (i_en) begin
      r_sig <= w_shift ^ i_fold;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/expr_vec_sequencer.sv
// Applies num_vec LFSR-generated operand vectors to an external datapath and
// compresses the registered results into a 32-bit MISR signature.
module expr_vec_sequencer
  import expr_seq_pkg::*;
#(
  parameter int VEC_W = DEF_VEC_W,
  parameter int RES_W = DEF_RES_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic [VEC_W-1:0] operands,
  input  logic [RES_W-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sig,
  output logic [CNT_W-1:0] vec_idx
);

  state_t           r_state;
  state_t           w_next;
  logic [63:0]      r_lfsr;
  logic [31:0]      r_seed;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_vec_idx;
  logic [RES_W-1:0] r_res_q;
  logic             r_res_v;
  logic             w_last;
  logic [95:0]      w_res_ext;
  logic [31:0]      w_fold;

  // Compare against num_vec-1 rather than vec_idx+1 so all-ones does not wrap
  assign w_last = (r_vec_idx == (r_num - CNT_W'(1)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = (r_num != '0) ? S_RUN : S_DONE;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lfsr    <= '0;
      r_seed    <= '0;
      r_num     <= '0;
      r_vec_idx <= '0;
      r_res_q   <= '0;
      r_res_v   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seed <= seed;
            r_num  <= num_vec;
          end
        end
        S_LOAD: begin
          r_lfsr    <= {~r_seed, r_seed};
          r_vec_idx <= '0;
          r_res_v   <= 1'b0;
        end
        S_RUN: begin
          r_res_q   <= result;
          r_res_v   <= 1'b1;
          r_lfsr    <= lfsr_step(r_lfsr);
          r_vec_idx <= r_vec_idx + CNT_W'(1);
        end
        S_DRAIN, S_DONE: r_res_v <= 1'b0;
        default: r_res_v <= 1'b0;
      endcase
    end
  end

  assign w_res_ext = 96'(r_res_q);
  assign w_fold    = w_res_ext[95:64] ^ w_res_ext[63:32] ^ w_res_ext[31:0];

  misr32 u_misr (
    .clk    (clk),
    .reset  (reset),
    .i_init (r_state == S_LOAD),
    .i_en   (r_res_v),
    .i_fold (w_fold),
    .o_sig  (sig)
  );

  assign operands = r_lfsr[VEC_W-1:0];
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign vec_idx  = r_vec_idx;

endmodule

// File: tb/tb_expr_vec_sequencer.sv
// Randomized bench for expr_vec_sequencer: a sweep-level model precomputes the
// operand sequence and signature at start and is compared every cycle.
module tb_expr_vec_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, tie_zero;
  logic [31:0] seed;
  logic [15:0] num_vec;
  logic [59:0] operands;
  logic [89:0] result;
  logic        busy, done;
  logic [31:0] sig;
  logic [15:0] vec_idx;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  expr_vec_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .seed     (seed),
    .num_vec  (num_vec),
    .operands (operands),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .sig      (sig),
    .vec_idx  (vec_idx)
  );

  // Golden datapath: lane products a_i*b_i in 15-bit slots, XORed with operands
  function automatic logic [89:0] dp(input logic [59:0] ops);
    logic [89:0] r;
    logic [4:0]  a, b;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      a = ops[59-5*i -: 5];
      b = ops[29-5*i -: 5];
      r = r + ((90'(a) * 90'(b)) << (15 * i));
    end
    return r ^ {ops, ops[29:0]};
  endfunction

  function automatic logic [63:0] nxt(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [89:0] r);
    logic [95:0] x;
    logic [31:0] f;
    x = {6'b0, r};
    f = x[95:64] ^ x[63:32] ^ x[31:0];
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ f;
  endfunction

  assign result = tie_zero ? '0 : dp(operands);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sweep model: whole operand list and final signature computed at acceptance
  bit          m_busy = 1'b0;
  int          m_t, m_len, m_n;
  logic [63:0] m_ops[$];
  logic [31:0] m_sig_final;
  logic [31:0] h_sig = '0;
  logic [59:0] h_ops = '0;
  logic [15:0] h_idx = '0;

  always @(posedge clk) begin : model
    logic [63:0] s;
    logic [31:0] g;
    if (reset) begin
      m_busy = 1'b0;
      h_sig  = '0;
      h_ops  = '0;
      h_idx  = '0;
    end else if (m_busy) begin
      if (m_t == m_len) begin
        m_busy = 1'b0;
        h_sig  = m_sig_final;
        h_ops  = m_ops[m_n][59:0];
        h_idx  = m_n[15:0];
      end else begin
        m_t++;
      end
    end else if (start) begin
      m_n    = int'(num_vec);
      m_len  = (m_n == 0) ? 2 : m_n + 3;
      m_t    = 1;
      m_busy = 1'b1;
      m_ops.delete();
      s = {~seed, seed};
      g = 32'hFFFF_FFFF;
      for (int k = 0; k <= m_n; k++) begin
        m_ops.push_back(s);
        if (k < m_n) begin
          g = misr(g, tie_zero ? 90'h0 : dp(s[59:0]));
          s = nxt(s);
        end
      end
      m_sig_final = g;
    end
  end

  always @(negedge clk) begin : compare
    int k;
    if (cmp_en) begin
      if (!m_busy) begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_sig", sig, h_sig);
        chk("idle_ops", operands, h_ops);
        chk("idle_idx", vec_idx, h_idx);
      end else begin
        chk("busy", busy, 1);
        chk("done", done, m_t == m_len);
        if (m_t == 1) begin
          chk("load_sig", sig, h_sig);
          chk("load_ops", operands, h_ops);
          chk("load_idx", vec_idx, h_idx);
        end else begin
          k = (m_t - 2 < m_n) ? m_t - 2 : m_n;
          chk("ops", operands, m_ops[k][59:0]);
          chk("vec_idx", vec_idx, k);
          if (m_t == m_len) chk("sig", sig, m_sig_final);
        end
      end
    end
  end

  // Issue one start and follow it until done; hold=1 keeps start high and
  // scrambles seed/num_vec while busy.
  task automatic sweep(input logic [31:0] sd, input logic [15:0] n, input bit tz,
                       input bit hold, output int lat, output int dones, output int bcnt);
    int lim;
    lim   = int'(n) + 12;
    lat   = -1;
    dones = 0;
    bcnt  = 0;
    @(negedge clk);
    seed = sd; num_vec = n; tie_zero = tz; start = 1'b1;
    for (int c = 1; c <= lim && lat < 0; c++) begin
      @(negedge clk);
      if (hold) begin
        seed    = $urandom;
        num_vec = 16'($urandom_range(0, 50));
      end else begin
        start = 1'b0;
      end
      if (busy && !done) bcnt++;
      if (done) begin
        dones++;
        lat   = c;
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  initial begin
    int          lat, dones, bcnt, rdone;
    logic [31:0] sd, iso;
    logic [15:0] n;
    reset = 1'b1; start = 1'b0; seed = '0; num_vec = '0; tie_zero = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", sig, 0);
    chk("rst_idx", vec_idx, 0);
    chk("rst_ops", operands, 0);
    reset = 1'b0;
    @(negedge clk);

    sweep(32'hA5A5_0001, 16'd0, 1'b0, 1'b0, lat, dones, bcnt);
    chk("n0_latency", lat, 2);
    chk("n0_sig", sig, 32'hFFFF_FFFF);
    chk("n0_idx", vec_idx, 0);
    chk("n0_dones", dones, 1);

    sweep(32'h1234_5678, 16'd1, 1'b1, 1'b0, lat, dones, bcnt);
    chk("n1_latency", lat, 4);
    chk("n1_sig", sig, 32'hFB3E_E249);
    chk("n1_model_ops0", m_ops[0][59:0], 60'hDCB_A987_1234_5678);
    chk("n1_model_sig", m_sig_final, 32'hFB3E_E249);

    sweep($urandom, 16'd100, 1'b0, 1'b0, lat, dones, bcnt);
    chk("n100_idx", vec_idx, 100);
    chk("n100_busy_before_done", bcnt, 102);
    chk("n100_latency", lat, 103);
    chk("n100_sig", sig, m_sig_final);

    sd = $urandom;
    sweep(sd, 16'd10, 1'b0, 1'b0, lat, dones, bcnt);
    iso = m_sig_final;
    chk("iso_sig", sig, iso);
    sweep(sd, 16'd10, 1'b0, 1'b1, lat, dones, bcnt);
    chk("hold_dones", dones, 1);
    chk("hold_latency", lat, 13);
    chk("hold_sig", sig, iso);

    // Abort on the 5th RUN cycle (cycles after accept: LOAD=1, RUN=2..)
    sd = $urandom;
    rdone = 0;
    @(negedge clk);
    seed = sd; num_vec = 16'd20; tie_zero = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) rdone++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (done) rdone++;
    chk("abort_busy", busy, 0);
    chk("abort_sig", sig, 0);
    chk("abort_no_done", rdone, 0);
    reset = 1'b0;
    sweep(sd, 16'd20, 1'b0, 1'b0, lat, dones, bcnt);
    chk("after_abort_sig", sig, m_sig_final);
    chk("after_abort_dones", dones, 1);

    repeat (8) begin
      n = 16'($urandom_range(0, 40));
      sweep($urandom, n, 1'($urandom_range(0, 1)), 1'b0, lat, dones, bcnt);
      chk("rand_latency", lat, (n == 0) ? 2 : int'(n) + 3);
      chk("rand_dones", dones, 1);
    end

    sweep($urandom, 16'hFFFF, 1'b0, 1'b0, lat, dones, bcnt);
    chk("max_idx", vec_idx, 16'hFFFF);
    chk("max_latency", lat, 65538);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
